// File: rtl/dc_pkg.sv
// Shared types and address-splitting helpers for the DRAM-cache request indexer.
// Optional feature: define DC_INDEX_HASH_EN to XOR-fold the next IDX_W address
// bits above the index into the set index (tag and FIFO payload are unaffected).
package dc_pkg;

    localparam int ID_W     = 16;
    localparam int ADDR_W   = 64;
    localparam int OFFSET_W = 6;
    localparam int IDX_W    = 4;
    localparam int TAG_W    = ADDR_W - OFFSET_W - IDX_W;
    localparam int FIFO_W   = 1 + ID_W + ADDR_W;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } chan_e;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [IDX_W-1:0] index;
        logic [TAG_W-1:0] tag;
        logic             write;
    } lookup_req_t;

    // Set index; with hashing the bits just above the index spread sequential
    // large strides across sets (needs TAG_W >= IDX_W so the slice exists).
    function automatic logic [IDX_W-1:0] dc_index(input logic [ADDR_W-1:0] addr);
        logic [IDX_W-1:0] idx;
        idx = addr[OFFSET_W +: IDX_W];
`ifdef DC_INDEX_HASH_EN
        idx = idx ^ addr[OFFSET_W+IDX_W +: IDX_W];
`else
        idx = idx;
`endif
        return idx;
    endfunction

    // Tag is everything above offset and index; offset bits are dropped.
    function automatic logic [TAG_W-1:0] dc_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/cache_req_indexer_if.sv
// Bus bundle for cache_req_indexer: AXI AR/AW request side, lookup output,
// write-FIFO push and statistics. slave = indexer side, master = surroundings.
interface cache_req_indexer_if
    import dc_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [ID_W-1:0]   req_id_o;
    logic [IDX_W-1:0]  req_index_o;
    logic [TAG_W-1:0]  req_tag_o;
    logic              req_write_o;
    logic              req_valid_o;
    logic              req_ready_i;
    logic              fifo_afull_i;
    logic              fifo_write_en_o;
    logic [FIFO_W-1:0] fifo_data_o;
    logic [CNT_W-1:0]  rd_cnt_o;
    logic [CNT_W-1:0]  wr_cnt_o;

    modport slave (
        input  arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i,
               req_ready_i, fifo_afull_i,
        output arready_o, awready_o, req_id_o, req_index_o, req_tag_o,
               req_write_o, req_valid_o, fifo_write_en_o, fifo_data_o,
               rd_cnt_o, wr_cnt_o
    );

    modport master (
        output arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i,
               req_ready_i, fifo_afull_i,
        input  arready_o, awready_o, req_id_o, req_index_o, req_tag_o,
               req_write_o, req_valid_o, fifo_write_en_o, fifo_data_o,
               rd_cnt_o, wr_cnt_o
    );

endinterface

// File: rtl/cache_req_indexer_rr_arb2.sv
// Two-requester round-robin arbiter (read vs write). The pointer names the
// channel that wins a tie and flips to the other channel after every grant.
module rr_arb2
    import dc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rd_ok,
    input  logic wr_ok,
    output logic grant_rd,
    output logic grant_wr
);

    chan_e rr_ptr_q, rr_ptr_d;

    // Grant decode and pointer update; grants are mutually exclusive.
    always_comb begin
        grant_rd = rd_ok & (~wr_ok | (rr_ptr_q == READ));
        grant_wr = wr_ok & ~grant_rd;
        rr_ptr_d = rr_ptr_q;
        if (grant_rd)      rr_ptr_d = WRITE;
        else if (grant_wr) rr_ptr_d = READ;
    end

    // Pointer register, reads favoured out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= READ;
        else        rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/cache_req_indexer.sv
// Merges AXI AR/AW requests into one registered tag-lookup stream, pushes
// accepted writes to the write FIFO and counts accepted reads/writes.
// Index hashing is selected at build time with DC_INDEX_HASH_EN.
module cache_req_indexer
    import dc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_req_indexer_if.slave  bus
);

    logic              out_free, rd_ok, wr_ok, grant_rd, grant_wr;
    lookup_req_t       req_q, req_d;
    logic              req_valid_q, req_valid_d;
    logic              fifo_we_q, fifo_we_d;
    logic [FIFO_W-1:0] fifo_data_q, fifo_data_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    // Channel eligibility: the single output slot must be free; writes also
    // need FIFO room, so a full FIFO never stalls reads.
    always_comb begin
        out_free = ~req_valid_q | bus.req_ready_i;
        rd_ok    = bus.arvalid_i & out_free;
        wr_ok    = bus.awvalid_i & out_free & ~bus.fifo_afull_i;
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_ok    (rd_ok),
        .wr_ok    (wr_ok),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    // Next lookup / FIFO push / counters; a stalled lookup simply holds.
    always_comb begin
        req_d       = req_q;
        req_valid_d = req_valid_q;
        fifo_we_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (grant_rd) begin
            req_d.id    = bus.arid_i;
            req_d.index = dc_index(bus.araddr_i);
            req_d.tag   = dc_tag(bus.araddr_i);
            req_d.write = 1'b0;
            req_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + CNT_W'(1);
        end else if (grant_wr) begin
            req_d.id    = bus.awid_i;
            req_d.index = dc_index(bus.awaddr_i);
            req_d.tag   = dc_tag(bus.awaddr_i);
            req_d.write = 1'b1;
            req_valid_d = 1'b1;
            fifo_we_d   = 1'b1;
            fifo_data_d = {1'b1, bus.awid_i, bus.awaddr_i};
            wr_cnt_d    = wr_cnt_q + CNT_W'(1);
        end else if (bus.req_ready_i) begin
            req_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held lookup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            fifo_we_q   <= fifo_we_d;
            fifo_data_q <= fifo_data_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign bus.arready_o       = grant_rd;
    assign bus.awready_o       = grant_wr;
    assign bus.req_id_o        = req_q.id;
    assign bus.req_index_o     = req_q.index;
    assign bus.req_tag_o       = req_q.tag;
    assign bus.req_write_o     = req_q.write;
    assign bus.req_valid_o     = req_valid_q;
    assign bus.fifo_write_en_o = fifo_we_q;
    assign bus.fifo_data_o     = fifo_data_q;
    assign bus.rd_cnt_o        = rd_cnt_q;
    assign bus.wr_cnt_o        = wr_cnt_q;

endmodule

// File: tb/tb_cache_req_indexer.sv
// Self-checking bench for cache_req_indexer: directed scenarios followed by
// random traffic, checked against an arithmetic reference model. A second
// instance with 4-bit counters shares the stimulus to exercise counter wrap.
module tb_cache_req_indexer;
    import dc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_req_indexer_if #(.CNT_W(32)) bus ();
    cache_req_indexer_if #(.CNT_W(4))  bus4 ();

    cache_req_indexer #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    cache_req_indexer #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    assign bus4.arid_i       = bus.arid_i;
    assign bus4.araddr_i     = bus.araddr_i;
    assign bus4.arvalid_i    = bus.arvalid_i;
    assign bus4.awid_i       = bus.awid_i;
    assign bus4.awaddr_i     = bus.awaddr_i;
    assign bus4.awvalid_i    = bus.awvalid_i;
    assign bus4.req_ready_i  = bus.req_ready_i;
    assign bus4.fifo_afull_i = bus.fifo_afull_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_valid, m_write, m_fwe, m_turn_wr, m_after_rst;
    logic [15:0] m_id;
    logic [3:0]  m_idx;
    logic [53:0] m_tag;
    logic [80:0] m_fdata;
    int unsigned m_rd, m_wr;
    bit          last_ar, last_aw;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_index(input logic [63:0] a);
        longint unsigned u;
        longint unsigned lo;
        longint unsigned hi;
        u  = a;
        lo = (u / 64) % 16;
        hi = (u / 1024) % 16;
`ifdef DC_INDEX_HASH_EN
        return 4'(lo ^ hi);
`else
        hi = 0;
        return 4'(lo ^ hi);
`endif
    endfunction

    function automatic logic [53:0] exp_tag(input logic [63:0] a);
        longint unsigned u;
        u = a;
        return 54'(u / 1024);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_write = 0; m_fwe = 0; m_turn_wr = 0;
        m_id = '0; m_idx = '0; m_tag = '0; m_fdata = '0;
        m_rd = 0; m_wr = 0; m_after_rst = 1;
    endtask

    // One clock: check readies before the edge, advance model, check registers after.
    task automatic cycle();
        bit free, rdok, wrok, grd, gwr;
        #1;
        free = !m_valid || bus.req_ready_i;
        rdok = bus.arvalid_i && free;
        wrok = bus.awvalid_i && free && !bus.fifo_afull_i;
        grd  = rdok && (!wrok || !m_turn_wr);
        gwr  = wrok && !grd;
        check("arready", bus.arready_o, grd);
        check("awready", bus.awready_o, gwr);
        last_ar = bus.arready_o;
        last_aw = bus.awready_o;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_after_rst = 0;
            m_fwe = 0;
            if (grd) begin
                m_valid = 1; m_write = 0; m_id = bus.arid_i;
                m_idx = exp_index(bus.araddr_i); m_tag = exp_tag(bus.araddr_i);
                m_rd++; m_turn_wr = 1;
            end else if (gwr) begin
                m_valid = 1; m_write = 1; m_id = bus.awid_i;
                m_idx = exp_index(bus.awaddr_i); m_tag = exp_tag(bus.awaddr_i);
                m_fwe = 1; m_fdata = {1'b1, bus.awid_i, bus.awaddr_i};
                m_wr++; m_turn_wr = 0;
            end else if (bus.req_ready_i) begin
                m_valid = 0;
            end
        end
        #1;
        check("req_valid", bus.req_valid_o, m_valid);
        check("fifo_we", bus.fifo_write_en_o, m_fwe);
        check("fifo_data", bus.fifo_data_o, m_fdata);
        check("rd_cnt", bus.rd_cnt_o, 32'(m_rd));
        check("wr_cnt", bus.wr_cnt_o, 32'(m_wr));
        check("rd_cnt4", bus4.rd_cnt_o, 4'(m_rd % 16));
        check("wr_cnt4", bus4.wr_cnt_o, 4'(m_wr % 16));
        if (m_valid || m_after_rst) begin
            check("req_id", bus.req_id_o, m_id);
            check("req_index", bus.req_index_o, m_idx);
            check("req_tag", bus.req_tag_o, m_tag);
            check("req_write", bus.req_write_o, m_write);
        end
    endtask

    task automatic drive(input bit arv, input bit awv, input bit rdy, input bit af);
        bus.arvalid_i    = arv;
        bus.awvalid_i    = awv;
        bus.req_ready_i  = rdy;
        bus.fifo_afull_i = af;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    initial begin
        bit [3:0] seq;
        model_reset();
        rst_n = 0;
        bus.arid_i = '0; bus.araddr_i = '0; bus.awid_i = '0; bus.awaddr_i = '0;
        drive(0, 0, 0, 0);
        cycle();
        cycle();
        rst_n = 1;

        // Reset state
        check("rst_valid", bus.req_valid_o, 1'b0);
        check("rst_rdcnt", bus.rd_cnt_o, 32'd0);

        // Single read lookup
        bus.arid_i = 16'd3; bus.araddr_i = 64'h1240;
        drive(1, 0, 1, 0);
        cycle();
`ifdef DC_INDEX_HASH_EN
        check("rd_index", bus.req_index_o, 4'hD);
`else
        check("rd_index", bus.req_index_o, 4'h9);
`endif
        check("rd_tag", bus.req_tag_o, 54'h4);
        check("rd_write", bus.req_write_o, 1'b0);
        check("rd_cnt1", bus.rd_cnt_o, 32'd1);

        // Both channels valid from reset: R,W,R,W
        do_reset();
        bus.awid_i = 16'hBEEF; bus.awaddr_i = 64'hDEAD_0000_1234_5678;
        drive(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            bus.araddr_i = 64'(i) << 10;
            bus.awaddr_i = 64'hDEAD_0000_1234_5678 + (64'(i) << 6);
            cycle();
            seq[i] = last_ar;
        end
        check("rr_seq", seq, 4'b0101);

        // Stall with a held lookup, then release
        drive(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("stall_ar", last_ar, 1'b0);
        drive(1, 1, 1, 0);
        cycle();
        check("release_grant", last_ar | last_aw, 1'b1);

        // FIFO almost full: reads only, then the write goes next
        drive(1, 1, 1, 1);
        for (int i = 0; i < 3; i++) cycle();
        check("afull_aw", last_aw, 1'b0);
        drive(1, 1, 1, 0);
        cycle();
        check("afull_release_aw", last_aw, 1'b1);

        // Mid-flight reset, pointer back to READ
        rst_n = 0;
        cycle();
        rst_n = 1;
        check("midrst_valid", bus.req_valid_o, 1'b0);
        check("midrst_fdata", bus.fifo_data_o, 81'd0);
        cycle();
        check("midrst_ptr", last_ar, 1'b1);

        // Counter wrap on the 4-bit instance
        do_reset();
        drive(1, 0, 1, 0);
        for (int i = 0; i < 16; i++) cycle();
        check("wrap4", bus4.rd_cnt_o, 4'd0);
        check("nowrap32", bus.rd_cnt_o, 32'd16);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            bus.arid_i   = 16'($urandom);
            bus.araddr_i = {$urandom, $urandom};
            bus.awid_i   = 16'($urandom);
            bus.awaddr_i = {$urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
